inst_rom_arb: RTL
=================

INST_ROM_ARB -- requirements
Module: inst_rom_arb

Interface
REQ-001 Parameter ADDR_W, default 32, address width of both requester ports and the ROM port.
REQ-002 Parameter DATA_W, default 32, instruction word width.
REQ-003 Parameter STARVE_LIM, default 4, legal range 1..15: consecutive cycles m1 may wait before it is forced to win.
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 rst  in  1  synchronous, active-low reset; rst=0 sampled at a rising edge resets the block.
REQ-006 m0_req  in  1  CPU fetch request; held with m0_addr stable until m0_gnt.
REQ-007 m0_addr  in  ADDR_W  CPU fetch address.
REQ-008 m0_gnt  out  1  combinational one-cycle grant; the address is accepted in this cycle.
REQ-009 m0_rdata  out  DATA_W  registered read data for m0.
REQ-010 m0_rvalid  out  1  one-cycle pulse; m0_rdata is valid.
REQ-011 m1_req, m1_addr, m1_gnt, m1_rdata, m1_rvalid: debug/loader port, same widths and rules as m0.
REQ-012 rom_ce  out  1  registered ROM enable.
REQ-013 rom_addr  out  ADDR_W  registered ROM address.
REQ-014 rom_data  in  DATA_W  combinational ROM output for rom_addr.

Function
REQ-015 At most one of m0_gnt, m1_gnt is high in any cycle.
REQ-016 Grant is combinational from the current req inputs and the starvation counter; it is never given to a requester whose req is low.
REQ-017 Default priority: m0 wins when both request, except as REQ-019 requires.
REQ-018 Starvation counter (4 bits): increments on each cycle m1_req=1 and m1_gnt=0; clears when m1_gnt=1 or m1_req=0; saturates at 15.
REQ-019 When the counter is >= STARVE_LIM and m1_req=1, m1 wins even if m0_req=1.
REQ-020 Pipeline: grant in cycle N -> rom_ce=1 and rom_addr=granted address in cycle N+1 -> rom_data captured into the owner's rdata at the end of N+1 -> owner's rvalid=1 in cycle N+2 only.
REQ-021 Throughput is one grant per cycle; back-to-back grants to either or mixed requesters are legal, and responses return in grant order.
REQ-022 The owner tag (m0/m1) travels with each pipeline stage; a response is never delivered to the non-owning port.
REQ-023 No grant in cycle N -> rom_ce=0 and rom_addr=0 in N+1; no rvalid in N+2.
REQ-024 The rdata of a port holds its last captured value until that port's next capture.
REQ-025 Both rvalid outputs are never high in the same cycle.

Reset
REQ-026 During reset: m0_gnt=m1_gnt=0 regardless of req inputs.
REQ-027 Reset values: rom_ce=0, rom_addr=0, m0_rdata=m1_rdata=0, m0_rvalid=m1_rvalid=0, starvation counter=0, pipeline owner valid bits=0.
REQ-028 Reset asserted mid-transaction discards in-flight accesses; no rvalid is produced for grants issued before or during reset.
REQ-029 First grant is possible in the first cycle with rst=1.

Verification
REQ-030 Only m0_req=1, m0_addr=0x00000004, rom returns 0x34011100 -> m0_gnt in cycle N, rom_ce=1/rom_addr=0x4 in N+1, m0_rvalid=1 with m0_rdata=0x34011100 in N+2.
REQ-031 Both req held continuously, STARVE_LIM=4 -> grants m0,m0,m0,m0,m1 then m0 repeatedly until m1 re-requests; counter returns to 0 after the m1 grant.
REQ-032 Alternating grants m0 @0x0, m1 @0x100, m0 @0x8 on consecutive cycles -> rvalid pulses m0,m1,m0 on consecutive cycles with matching data and no cross-delivery.
REQ-033 m1_req=1 alone for 20 cycles while the ROM is free -> m1_gnt every cycle and counter stays 0.
REQ-034 rst=0 in cycle N+1 after a grant in N -> no rvalid in N+2, all outputs at reset values, and a normal grant in the first cycle after rst returns to 1.
REQ-035 Idle (no req) -> rom_ce=0, rom_addr=0, no gnt or rvalid; rdata retains the previous value.

Source files
------------

// File: rtl/inst_rom_arb.sv
// inst_rom_arb: two-port arbiter in front of a single-cycle instruction ROM.
// m0 (CPU fetch) has default priority. m1 (debug/loader) wins once it has
// waited STARVE_LIM cycles. Each access runs a fixed two-stage pipeline:
// the grant cycle, then the ROM cycle, then rvalid to the owning port.
module inst_rom_arb #(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned STARVE_LIM = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              m0_req,
  input  logic [ADDR_W-1:0] m0_addr,
  output logic              m0_gnt,
  output logic [DATA_W-1:0] m0_rdata,
  output logic              m0_rvalid,
  input  logic              m1_req,
  input  logic [ADDR_W-1:0] m1_addr,
  output logic              m1_gnt,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              m1_rvalid,
  output logic              rom_ce,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_data
);

  localparam logic [3:0] LIM = 4'(STARVE_LIM);

  // Starvation counter increments but holds at its maximum value.
  function automatic logic [3:0] sat_inc(input logic [3:0] v);
    return (v == 4'hF) ? v : v + 4'd1;
  endfunction

  logic [3:0]        cnt_q, cnt_d;
  logic              rom_ce_q, rom_ce_d;
  logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
  logic              own_q, own_d;        // owner of the ROM-stage access: 1 = m1
  logic [DATA_W-1:0] m0_rdata_q, m0_rdata_d;
  logic [DATA_W-1:0] m1_rdata_q, m1_rdata_d;
  logic              m0_rvalid_q, m0_rvalid_d;
  logic              m1_rvalid_q, m1_rvalid_d;
  logic              force_m1;

  // Combinational grant: m0 first unless m1 has waited too long; nothing in reset.
  always_comb begin
    force_m1 = m1_req && (cnt_q >= LIM);
    m1_gnt   = rst && m1_req && (force_m1 || !m0_req);
    m0_gnt   = rst && m0_req && !(force_m1);
  end

  // Next-state: starvation count, ROM stage launch, response capture.
  always_comb begin
    cnt_d = (m1_req && !m1_gnt) ? sat_inc(cnt_q) : 4'd0;

    // Grant stage -> ROM stage
    rom_ce_d   = m0_gnt || m1_gnt;
    rom_addr_d = '0;
    if (m1_gnt) begin
      rom_addr_d = m1_addr;
    end else if (m0_gnt) begin
      rom_addr_d = m0_addr;
    end
    own_d = m1_gnt;

    // ROM stage -> response stage
    m0_rvalid_d = rom_ce_q && !own_q;
    m1_rvalid_d = rom_ce_q && own_q;
    m0_rdata_d  = m0_rvalid_d ? rom_data : m0_rdata_q;
    m1_rdata_d  = m1_rvalid_d ? rom_data : m1_rdata_q;
  end

  // State registers; active-low synchronous reset drops any in-flight access.
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q       <= '0;
      rom_ce_q    <= 1'b0;
      rom_addr_q  <= '0;
      own_q       <= 1'b0;
      m0_rdata_q  <= '0;
      m1_rdata_q  <= '0;
      m0_rvalid_q <= 1'b0;
      m1_rvalid_q <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      rom_ce_q    <= rom_ce_d;
      rom_addr_q  <= rom_addr_d;
      own_q       <= own_d;
      m0_rdata_q  <= m0_rdata_d;
      m1_rdata_q  <= m1_rdata_d;
      m0_rvalid_q <= m0_rvalid_d;
      m1_rvalid_q <= m1_rvalid_d;
    end
  end

  assign rom_ce    = rom_ce_q;
  assign rom_addr  = rom_addr_q;
  assign m0_rdata  = m0_rdata_q;
  assign m1_rdata  = m1_rdata_q;
  assign m0_rvalid = m0_rvalid_q;
  assign m1_rvalid = m1_rvalid_q;

endmodule
